traffic_intersection_ctrl: RTL and testbench
============================================

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter TW, default 8, the phase-timer width in bits.
REQ-002 SHALL have parameter T_GREEN, default 20, the green phase length in ticks.
REQ-003 SHALL have parameter T_YELLOW, default 3, the yellow phase length in ticks.
REQ-004 SHALL have parameter T_ALLRED, default 2, the all-red clearance length in ticks.
REQ-005 SHALL have parameter T_WALK, default 10, the pedestrian walk length in ticks.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-008 SHALL have port tick, input, 1 bit: one-cycle time-base enable; timing advances only when tick=1.
REQ-009 SHALL have port ped_req, input, 1 bit: pedestrian request, level or pulse.
REQ-010 SHALL have port night_mode, input, 1 bit: request for flashing-yellow operation.
REQ-011 SHALL have ports ns_red, ns_yellow, ns_green, output, 1 bit each: north-south lamps.
REQ-012 SHALL have ports ew_red, ew_yellow, ew_green, output, 1 bit each: east-west lamps.
REQ-013 SHALL have port walk, output, 1 bit: pedestrian walk lamp.
REQ-014 SHALL have port phase, output, 3 bits: current state encoding, for debug.

Function
REQ-015 SHALL implement states NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2, PED_WALK and FLASH.
REQ-016 SHALL load the timer with duration-1 on entry to each timed state and decrement it on each tick.
REQ-017 SHALL leave a state on a cycle when tick=1 and timer==0, so each state lasts exactly its duration in ticks.
REQ-018 SHALL follow the normal sequence NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN.
REQ-019 SHALL set a ped_pending flag on any cycle with ped_req=1 while not in PED_WALK or FLASH; requests in those states are ignored.
REQ-020 SHALL, at ALL_RED_x expiry with ped_pending=1, enter PED_WALK (duration T_WALK) and clear ped_pending; on exit go to the green that ALL_RED_x would have entered.
REQ-021 SHALL sample night_mode only at ALL_RED_x and PED_WALK expiry; if it is 1, enter FLASH.
REQ-022 SHALL give PED_WALK priority over FLASH when both are due at ALL_RED_x expiry.
REQ-023 SHALL, in FLASH, toggle a blink bit on every tick, drive ns_yellow=ew_yellow=blink with all other lamps 0, and clear ped_pending on entry.
REQ-024 SHALL, in FLASH with night_mode=0 on a tick, go to ALL_RED_2 (T_ALLRED), then NS_GREEN.
REQ-025 SHALL decode lamps from state (Moore): a green/yellow state lights its lamp and the other direction's red; ALL_RED_x and PED_WALK light both reds; walk=1 only in PED_WALK.
REQ-026 SHALL never assert green or yellow in both directions simultaneously outside FLASH.
REQ-027 SHALL require all durations to be >=1 and <2^TW; violating elaborations SHALL fail.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, enter ALL_RED_2 with timer=T_ALLRED-1, ped_pending=0, blink=0.
REQ-029 SHALL hold reset output values ns_red=ew_red=1, all other lamps 0, walk=0 and phase=ALL_RED_2.
REQ-030 SHALL abort any phase immediately when reset is asserted mid-operation, and ignore tick during reset.

Structure
REQ-031 SHALL place the state enum and its 3-bit encoding in shared package traffic_pkg.
REQ-032 SHALL use one sub-module, phase_timer: a TW-bit loadable down-counter with tick enable and zero flag.

Verification (tick=1 every cycle; G=4, Y=2, AR=1, WALK=3)
REQ-033 Release reset -> 1 cycle both red, then NS green 4, NS yellow 2, all-red 1, EW green 4, EW yellow 2, all-red 1; period 14 cycles.
REQ-034 ped_req pulse during NS_GREEN -> after ALL_RED_1: walk=1 for 3 cycles with both reds, then EW_GREEN.
REQ-035 night_mode=1 during EW_GREEN -> FLASH after ALL_RED_2 with both yellows toggling each cycle; night_mode=0 -> all-red 1, then NS_GREEN.
REQ-036 ped_req and night_mode both pending at ALL_RED_1 expiry -> PED_WALK for 3 cycles, then FLASH.
REQ-037 tick=1 every 3rd cycle -> NS_GREEN lasts 12 cycles; reset asserted mid EW_YELLOW -> next cycle both red, phase=ALL_RED_2.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp decode for the intersection controller.
// Lamps are a pure function of phase (plus the flash blink bit).
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_1 = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_2 = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } phase_e;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    function automatic lamps_t decode_lamps(input phase_e ph, input logic blink);
        lamps_t l;
        l = '0;
        case (ph)
            NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
            NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
            EW_GREEN:  begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
            EW_YELLOW: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
            ALL_RED_1,
            ALL_RED_2: begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
            PED_WALK:  begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
            FLASH:     begin l.ns_yellow = blink; l.ew_yellow = blink; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter: load wins over tick, counting stops at zero.
// zero_o flags the last tick of the current phase.
module phase_timer #(
    parameter int             TW      = 8,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          tick_i,
    output logic          zero_o
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection controller with pedestrian walk and night flashing mode.
// Phase timing advances only on tick; lamps are registered from the next phase.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int TW       = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam longint DMAX = (longint'(1) << TW) - 1;
    localparam bit DUR_OK = (TW >= 1) && (TW <= 31)
                         && (T_GREEN  >= 1) && (T_GREEN  <= DMAX)
                         && (T_YELLOW >= 1) && (T_YELLOW <= DMAX)
                         && (T_ALLRED >= 1) && (T_ALLRED <= DMAX)
                         && (T_WALK   >= 1) && (T_WALK   <= DMAX);

    if (!DUR_OK) begin : g_bad_duration
        $fatal(1, "traffic_intersection_ctrl: every duration must lie in [1, 2**TW-1]");
    end

    localparam logic [TW-1:0] LD_GREEN  = TW'(T_GREEN  - 1);
    localparam logic [TW-1:0] LD_YELLOW = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] LD_ALLRED = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] LD_WALK   = TW'(T_WALK   - 1);

    phase_e        state_q, state_d;
    phase_e        ret_q, ret_d;
    logic          ped_q, ped_d;
    logic          blink_q, blink_d;
    lamps_t        lamps_q;
    logic          timer_zero;
    logic          expire;
    logic          load;
    logic [TW-1:0] load_val;

    phase_timer #(
        .TW      (TW),
        .RST_VAL (LD_ALLRED)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .load_val_i (load_val),
        .tick_i     (tick),
        .zero_o     (timer_zero)
    );

    assign expire = tick && timer_zero;

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        blink_d  = blink_q;
        ped_d    = ped_q | (ped_req && (state_q != PED_WALK) && (state_q != FLASH));
        load_val = '0;
        case (state_q)
            NS_GREEN:  if (expire) state_d = NS_YELLOW;
            NS_YELLOW: if (expire) state_d = ALL_RED_1;
            EW_GREEN:  if (expire) state_d = EW_YELLOW;
            EW_YELLOW: if (expire) state_d = ALL_RED_2;
            ALL_RED_1,
            ALL_RED_2: begin
                if (expire) begin
                    // Remember which green the clearance was heading for, so a walk can resume it.
                    ret_d = (state_q == ALL_RED_1) ? EW_GREEN : NS_GREEN;
                    if (ped_q)           state_d = PED_WALK;
                    else if (night_mode) state_d = FLASH;
                    else                 state_d = ret_d;
                end
            end
            PED_WALK:  if (expire) state_d = night_mode ? FLASH : ret_q;
            FLASH: begin
                if (tick) begin
                    blink_d = ~blink_q;
                    if (!night_mode) state_d = ALL_RED_2;
                end
            end
        endcase

        if ((state_d != state_q) && ((state_d == PED_WALK) || (state_d == FLASH))) begin
            ped_d = 1'b0;
        end

        load = (state_d != state_q);
        case (state_d)
            NS_GREEN, EW_GREEN:   load_val = LD_GREEN;
            NS_YELLOW, EW_YELLOW: load_val = LD_YELLOW;
            ALL_RED_1, ALL_RED_2: load_val = LD_ALLRED;
            PED_WALK:             load_val = LD_WALK;
            FLASH:                load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ALL_RED_2;
            ret_q   <= NS_GREEN;
            ped_q   <= 1'b0;
            blink_q <= 1'b0;
            lamps_q <= decode_lamps(ALL_RED_2, 1'b0);
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            ped_q   <= ped_d;
            blink_q <= blink_d;
            lamps_q <= decode_lamps(state_d, blink_d);
        end
    end

    assign ns_red    = lamps_q.ns_red;
    assign ns_yellow = lamps_q.ns_yellow;
    assign ns_green  = lamps_q.ns_green;
    assign ew_red    = lamps_q.ew_red;
    assign ew_yellow = lamps_q.ew_yellow;
    assign ew_green  = lamps_q.ew_green;
    assign walk      = lamps_q.walk;
    assign phase     = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed scenarios plus a randomized run against a tick-counting reference model.
// Short durations (G=4, Y=2, AR=1, WALK=3) keep every scenario brief.
module tb_traffic_intersection_ctrl;
    import traffic_pkg::*;

    localparam int G  = 4;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int WK = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
    logic [2:0] phase;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .TW       (8),
        .T_GREEN  (G),
        .T_YELLOW (Y),
        .T_ALLRED (AR),
        .T_WALK   (WK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .walk       (walk),
        .phase      (phase)
    );

    wire [6:0] lamps_obs = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

    // Reference model: counts remaining ticks of the current phase.
    phase_e m_st  = ALL_RED_2;
    phase_e m_ret = NS_GREEN;
    int     m_left = AR;
    bit     m_ped = 1'b0;
    bit     m_blink = 1'b0;

    function automatic int dur(input phase_e s);
        case (s)
            NS_GREEN, EW_GREEN:   return G;
            NS_YELLOW, EW_YELLOW: return Y;
            ALL_RED_1, ALL_RED_2: return AR;
            PED_WALK:             return WK;
            default:              return 0;
        endcase
    endfunction

    // Lamp order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    function automatic logic [6:0] exp_lamps(input phase_e s, input bit b);
        case (s)
            NS_GREEN:  return 7'b0011000;
            NS_YELLOW: return 7'b0101000;
            EW_GREEN:  return 7'b1000010;
            EW_YELLOW: return 7'b1000100;
            PED_WALK:  return 7'b1001001;
            FLASH:     return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
            default:   return 7'b1001000;
        endcase
    endfunction

    task automatic mdl_step();
        bit     ped_old;
        phase_e nx;
        if (reset) begin
            m_st = ALL_RED_2; m_left = AR; m_ped = 1'b0; m_blink = 1'b0; m_ret = NS_GREEN;
            return;
        end
        ped_old = m_ped;
        if (ped_req && m_st != PED_WALK && m_st != FLASH) m_ped = 1'b1;
        nx = m_st;
        if (m_st == FLASH) begin
            if (tick) begin
                m_blink = !m_blink;
                if (!night_mode) nx = ALL_RED_2;
            end
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                case (m_st)
                    NS_GREEN:  nx = NS_YELLOW;
                    NS_YELLOW: nx = ALL_RED_1;
                    EW_GREEN:  nx = EW_YELLOW;
                    EW_YELLOW: nx = ALL_RED_2;
                    ALL_RED_1, ALL_RED_2: begin
                        m_ret = (m_st == ALL_RED_1) ? EW_GREEN : NS_GREEN;
                        nx = ped_old ? PED_WALK : (night_mode ? FLASH : m_ret);
                    end
                    PED_WALK:  nx = night_mode ? FLASH : m_ret;
                    default:   nx = m_st;
                endcase
            end
        end
        if (nx != m_st) begin
            if (nx == PED_WALK || nx == FLASH) m_ped = 1'b0;
            m_st = nx;
            m_left = dur(nx);
        end
    endtask

    task automatic step();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic run_until(input phase_e target, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (phase == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; ped_req = 1'b1; night_mode = 1'b1;
        step(); step(); step();
        checks++;
        if (lamps_obs !== 7'b1001000) $display("FAIL reset_lamps: got %b want %b", lamps_obs, 7'b1001000);
        else passes++;
        checks++;
        if (phase !== ALL_RED_2) $display("FAIL reset_phase: got %0d want %0d", phase, ALL_RED_2);
        else passes++;
        ped_req = 1'b0; night_mode = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_normal_cycle();
        phase_e seq [14] = '{NS_GREEN, NS_GREEN, NS_GREEN, NS_GREEN, NS_YELLOW, NS_YELLOW, ALL_RED_1,
                             EW_GREEN, EW_GREEN, EW_GREEN, EW_GREEN, EW_YELLOW, EW_YELLOW, ALL_RED_2};
        do_reset();
        tick = 1'b1;
        checks++;
        if (phase !== ALL_RED_2) $display("FAIL first_cycle_red: got %0d want %0d", phase, ALL_RED_2);
        else passes++;
        for (int i = 0; i < 28; i++) begin
            step();
            checks++;
            if ({phase, lamps_obs} !== {3'(seq[i % 14]), exp_lamps(seq[i % 14], 1'b0)})
                $display("FAIL normal_cycle[%0d]: got phase %0d lamps %b want phase %0d lamps %b",
                         i, phase, lamps_obs, seq[i % 14], exp_lamps(seq[i % 14], 1'b0));
            else passes++;
        end
    endtask

    task automatic test_ped();
        bit ok;
        int n;
        do_reset();
        tick = 1'b1;
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        run_until(ALL_RED_1, 20, ok);
        checks++;
        if (!ok) $display("FAIL ped_reach_allred1: got timeout want ALL_RED_1");
        else passes++;
        step();
        checks++;
        if ({phase, lamps_obs} !== {3'(PED_WALK), 7'b1001001})
            $display("FAIL ped_walk_entry: got phase %0d lamps %b want phase %0d lamps 1001001", phase, lamps_obs, PED_WALK);
        else passes++;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (phase == PED_WALK) n++;
            else break;
        end
        checks++;
        if (n !== WK) $display("FAIL ped_walk_len: got %0d want %0d", n, WK);
        else passes++;
        checks++;
        if (phase !== EW_GREEN) $display("FAIL ped_resume: got %0d want %0d", phase, EW_GREEN);
        else passes++;
    endtask

    task automatic test_night();
        bit   ok;
        logic prev;
        do_reset();
        tick = 1'b1;
        run_until(EW_GREEN, 20, ok);
        night_mode = 1'b1;
        run_until(FLASH, 20, ok);
        checks++;
        if (!ok) $display("FAIL night_reach_flash: got timeout want FLASH");
        else passes++;
        for (int i = 0; i < 6; i++) begin
            prev = ns_yellow;
            step();
            checks++;
            if ({ns_red, ns_green, ew_red, ew_green, walk} !== 5'b0 || ew_yellow !== ns_yellow || ns_yellow !== !prev)
                $display("FAIL flash_toggle[%0d]: got lamps %b prev_yellow %b want yellows toggled, others 0",
                         i, lamps_obs, prev);
            else passes++;
        end
        night_mode = 1'b0;
        step();
        checks++;
        if ({phase, lamps_obs} !== {3'(ALL_RED_2), 7'b1001000})
            $display("FAIL flash_exit_allred: got phase %0d lamps %b want phase %0d lamps 1001000", phase, lamps_obs, ALL_RED_2);
        else passes++;
        step();
        checks++;
        if (phase !== NS_GREEN) $display("FAIL flash_exit_green: got %0d want %0d", phase, NS_GREEN);
        else passes++;
    endtask

    task automatic test_ped_and_night();
        bit ok;
        do_reset();
        tick = 1'b1;
        step();
        ped_req = 1'b1;
        night_mode = 1'b1;
        step();
        ped_req = 1'b0;
        run_until(ALL_RED_1, 20, ok);
        checks++;
        if (!ok) $display("FAIL both_reach_allred1: got timeout want ALL_RED_1");
        else passes++;
        step();
        checks++;
        if (phase !== PED_WALK) $display("FAIL both_walk_first: got %0d want %0d", phase, PED_WALK);
        else passes++;
        step(); step();
        checks++;
        if (phase !== PED_WALK) $display("FAIL both_walk_third: got %0d want %0d", phase, PED_WALK);
        else passes++;
        step();
        checks++;
        if (phase !== FLASH) $display("FAIL both_then_flash: got %0d want %0d", phase, FLASH);
        else passes++;
        night_mode = 1'b0;
        step(); step();
    endtask

    task automatic test_slow_tick();
        int  cyc;
        int  n;
        bit  ok;
        do_reset();
        cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick = (cyc % 3 == 0); step(); cyc++;
            if (phase == NS_GREEN) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) $display("FAIL slow_reach_green: got timeout want NS_GREEN");
        else passes++;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick = (cyc % 3 == 0); step(); cyc++;
            if (phase == NS_GREEN) n++;
            else break;
        end
        checks++;
        if (n !== 3 * G) $display("FAIL slow_green_len: got %0d want %0d", n, 3 * G);
        else passes++;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick = (cyc % 3 == 0); step(); cyc++;
            if (phase == EW_YELLOW) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) $display("FAIL slow_reach_ewy: got timeout want EW_YELLOW");
        else passes++;
        reset = 1'b1;
        tick = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({phase, lamps_obs} !== {3'(ALL_RED_2), 7'b1001000})
            $display("FAIL reset_mid: got phase %0d lamps %b want phase %0d lamps 1001000", phase, lamps_obs, ALL_RED_2);
        else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick    = ($urandom_range(0, 3) != 0);
            ped_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 59) == 0) night_mode = !night_mode;
            reset   = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if ({phase, lamps_obs} !== {3'(m_st), exp_lamps(m_st, m_blink)})
                $display("FAIL random[%0d]: got phase %0d lamps %b want phase %0d lamps %b",
                         i, phase, lamps_obs, m_st, exp_lamps(m_st, m_blink));
            else passes++;
            if (phase != FLASH) begin
                checks++;
                if ((ns_green | ns_yellow) && (ew_green | ew_yellow))
                    $display("FAIL conflict[%0d]: got lamps %b want no cross-direction go", i, lamps_obs);
                else passes++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped();
        test_night();
        test_ped_and_night();
        test_slow_tick();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
